// File: rtl/nr_divider.sv
// nr_divider: sequential non-restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and explicit divide-by-zero reporting.
// Optional signed mode: define DIV_SIGNED_EN to treat the operands as two's
// complement; this adds one SIGN state after FIX, so latency grows by one.
module nr_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    logic [AW-1:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    a_shift;
    logic [AW-1:0]    a_add;
    logic [AW-1:0]    a_sub;
    logic [AW-1:0]    a_next;
    logic [WIDTH-1:0] q_next;
    logic [AW-1:0]    a_fix;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;

`ifdef DIV_SIGNED_EN
    logic neg_dvd;
    logic neg_quo;
`endif

    // One non-restoring step on {A,Q} plus the final remainder correction.
    always_comb begin
        m_ext   = {1'b0, m};
        a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
        a_add   = a_shift + m_ext;
        a_sub   = a_shift + ~m_ext + AW'(1);
        a_next  = a[WIDTH] ? a_add : a_sub;
        q_next  = {q[WIDTH-2:0], ~a_next[WIDTH]};
        a_fix   = a[WIDTH] ? (a + m_ext) : a;
    end

    // Operand magnitudes loaded at launch; plain operands in unsigned mode.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_in = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
        dvs_in = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
`else
        dvd_in = dividend;
        dvs_in = divisor;
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_dvd     <= 1'b0;
            neg_quo     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            // Divide by zero skips the iteration entirely.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            m     <= dvs_in;
                            q     <= dvd_in;
                            a     <= '0;
                            cnt   <= '0;
                            state <= CALC;
`ifdef DIV_SIGNED_EN
                            neg_dvd <= dividend[WIDTH-1];
                            neg_quo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`endif
                        end
                    end
                end

                CALC: begin
                    a   <= a_next;
                    q   <= q_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    a <= a_fix;
`ifdef DIV_SIGNED_EN
                    state <= SIGN;
`else
                    quotient    <= q;
                    remainder   <= a_fix[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
`endif
                end

`ifdef DIV_SIGNED_EN
                SIGN: begin
                    // Quotient sign from the operand signs, remainder follows the dividend.
                    quotient    <= neg_quo ? (~q + WIDTH'(1)) : q;
                    remainder   <= neg_dvd ? (~a[WIDTH-1:0] + WIDTH'(1)) : a[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
`endif

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// Self-checking bench for nr_divider: directed cases with literal results
// plus randomized traffic checked every cycle against a behavioural model.
module tb_nr_divider;

`ifdef DIV_SIGNED_EN
    localparam int unsigned W   = 8;
    localparam int          LAT = W + 3;
`else
    localparam int unsigned W   = 16;
    localparam int          LAT = W + 2;
`endif

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    nr_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operand semantics.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DIV_SIGNED_EN
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return W'(sx / sy);
`else
        return x / y;
`endif
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DIV_SIGNED_EN
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return W'(sx % sy);
`else
        return x % y;
`endif
    endfunction

    // Behavioural model: a launch produces its result LAT cycles later (1 for /0).
    logic         m_busy, m_done, m_z, p_z;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_left;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
            p_q    <= '0;
            p_r    <= '0;
            p_z    <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_z    <= p_z;
            end
            m_left <= m_left - 1;
        end else if (start) begin
            m_busy <= 1'b1;
            if (divisor == '0) begin
                m_done <= 1'b1;
                m_q    <= '1;
                m_r    <= dividend;
                m_z    <= 1'b1;
            end else begin
                p_q    <= ref_q(dividend, divisor);
                p_r    <= ref_r(dividend, divisor);
                p_z    <= 1'b0;
                m_left <= LAT - 1;
            end
        end
    end

    // Per-cycle compare of every output against the model, away from the edge.
    always @(posedge clk) begin
        #2;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
    end

    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        dividend = x;
        divisor  = y;
        start    = 1'b1;
        @(posedge clk);
    endtask

    // Counts falling edges until done is seen; 0 means the bound expired.
    task automatic wait_done(input int max, input bit drop, output int lat);
        lat = 0;
        for (int n = 1; n <= max; n++) begin
            @(negedge clk);
            if (drop) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout bound=%0d t=%0t", max, $time);
        end
    endtask

    function automatic logic [W-1:0] pick();
        int sel;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int seen;
        int dl;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        n_rst    = 1'b1;
        #3 n_rst = 1'b0;
        #5;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

`ifndef DIV_SIGNED_EN
        go(16'd100, 16'd7);
        wait_done(40, 1'b1, lat);
        chk("t1_lat", 32'(lat), 32'd18);
        chk("t1_q", 32'(quotient), 32'd14);
        chk("t1_r", 32'(remainder), 32'd2);
        chk("t1_z", 32'(div_by_zero), 32'd0);

        go(16'hFFFF, 16'd1);
        wait_done(40, 1'b0, lat);
        chk("t2a_lat", 32'(lat), 32'd18);
        chk("t2a_q", 32'(quotient), 32'hFFFF);
        chk("t2a_r", 32'(remainder), 32'd0);
        dividend = 16'd3;
        divisor  = 16'd10;
        wait_done(40, 1'b0, lat);
        start = 1'b0;
        chk("t2b_spacing", 32'(lat), 32'd19);
        chk("t2b_q", 32'(quotient), 32'd0);
        chk("t2b_r", 32'(remainder), 32'd3);

        go(16'd5, 16'd0);
        wait_done(5, 1'b1, lat);
        chk("t3a_lat", 32'(lat), 32'd1);
        chk("t3a_q", 32'(quotient), 32'hFFFF);
        chk("t3a_r", 32'(remainder), 32'd5);
        chk("t3a_z", 32'(div_by_zero), 32'd1);
        go(16'd9, 16'd3);
        wait_done(40, 1'b1, lat);
        chk("t3b_q", 32'(quotient), 32'd3);
        chk("t3b_r", 32'(remainder), 32'd0);
        chk("t3b_z", 32'(div_by_zero), 32'd0);

        go(16'd100, 16'd7);
        seen = 0;
        dl   = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 5) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 16'd5;
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                seen++;
                if (dl == 0) dl = n;
                chk("t4_q", 32'(quotient), 32'd14);
                chk("t4_r", 32'(remainder), 32'd2);
            end
        end
        chk("t4_lat", 32'(dl), 32'd18);
        chk("t4_ndone", 32'(seen), 32'd1);

        go(16'd100, 16'd7);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_q", 32'(quotient), 32'd0);
        chk("t5_r", 32'(remainder), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        seen = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("t5_nodone", 32'(seen), 32'd0);
        go(16'd20, 16'd6);
        wait_done(40, 1'b1, lat);
        chk("t5b_lat", 32'(lat), 32'd18);
        chk("t5b_q", 32'(quotient), 32'd3);
        chk("t5b_r", 32'(remainder), 32'd2);
`else
        go(8'h9C, 8'h07);
        wait_done(40, 1'b1, lat);
        chk("s1_lat", 32'(lat), 32'd11);
        chk("s1_q", 32'(quotient), 32'hF2);
        chk("s1_r", 32'(remainder), 32'hFE);
        go(8'h80, 8'hFF);
        wait_done(40, 1'b1, lat);
        chk("s2_q", 32'(quotient), 32'h80);
        chk("s2_r", 32'(remainder), 32'h00);
        go(8'h85, 8'h00);
        wait_done(5, 1'b1, lat);
        chk("s3_lat", 32'(lat), 32'd1);
        chk("s3_q", 32'(quotient), 32'hFF);
        chk("s3_r", 32'(remainder), 32'h85);
        chk("s3_z", 32'(div_by_zero), 32'd1);
`endif

        // Random traffic: starts while busy, operand churn, zero and edge divisors.
        repeat (3000) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = pick();
            divisor  = pick();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
